// File: rtl/span_pixel_writer_if.sv
// rtl/span_pixel_writer_if.sv - span pixel stream and framebuffer write port bundle
//
// Purpose: groups the span control, pixel stream and masked memory write
// signals of span_pixel_writer.
// Modports:
//   master - span/pixel source and memory side: drives start, y, colr, x,
//            valid, flush, mem_ready; observes oe, busy, done, mem_*.
//   slave  - span_pixel_writer itself.
interface span_pixel_writer_if #(
    parameter int CORDW = 16,
    parameter int WORD  = 32,
    parameter int BPP   = 4,
    parameter int ADDRW = 16
);
    localparam int PPW = WORD / BPP;

    logic                    start;
    logic signed [CORDW-1:0] y;
    logic [BPP-1:0]          colr;
    logic signed [CORDW-1:0] x;
    logic                    valid;
    logic                    flush;
    logic                    oe;
    logic                    busy;
    logic                    done;
    logic [ADDRW-1:0]        mem_addr;
    logic [WORD-1:0]         mem_data;
    logic [PPW-1:0]          mem_mask;
    logic                    mem_valid;
    logic                    mem_ready;

    modport master (
        output start, y, colr, x, valid, flush, mem_ready,
        input  oe, busy, done, mem_addr, mem_data, mem_mask, mem_valid
    );

    modport slave (
        input  start, y, colr, x, valid, flush, mem_ready,
        output oe, busy, done, mem_addr, mem_data, mem_mask, mem_valid
    );
endinterface

// File: rtl/span_pixel_writer.sv
// rtl/span_pixel_writer.sv - packs span pixels into masked framebuffer word writes
//
// Purpose: consumes one x per handshake on a latched row/colour, gathers
// pixels of the same framebuffer word into an accumulator with a per-pixel
// mask, and issues masked word writes whenever the word index changes or the
// span is flushed.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - span_pixel_writer_if.slave: start/y/colr span control,
//              x/valid/oe pixel stream, flush end-of-span, busy/done status,
//              mem_addr/mem_data/mem_mask/mem_valid/mem_ready write port
module span_pixel_writer #(
    parameter int CORDW     = 16,
    parameter int WORD      = 32,
    parameter int BPP       = 4,
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDRW     = 16
) (
    input  logic clk,
    input  logic rst,
    span_pixel_writer_if.slave bus
);
    localparam int PPW   = WORD / BPP;
    localparam int SLOTW = $clog2(PPW);
    localparam int WPL   = FB_WIDTH / PPW;

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;

    state_t                  state, state_next;
    logic signed [CORDW-1:0] y_r;
    logic [BPP-1:0]          colr_r;
    logic [ADDRW-1:0]        acc_idx;
    logic [PPW-1:0]          acc_mask;
    logic [WORD-1:0]         acc_data;
    logic                    flush_pend;
    logic                    final_r;

    logic                    in_range;
    logic                    pix_ok;
    logic                    wchg;
    logic                    issue_final;
    logic [SLOTW-1:0]        slot;
    logic [ADDRW-1:0]        pix_idx;
    logic [PPW-1:0]          pix_mask;
    logic [WORD-1:0]         pix_data;
    logic [WORD-1:0]         pix_clr;
    logic [ADDRW-1:0]        merge_idx;
    logic [PPW-1:0]          merge_mask;
    logic [WORD-1:0]         merge_data;

    assign bus.oe = (state == ACCUM);

    // Sign bits are tested first so the upper-bound compares only see
    // non-negative values.
    assign in_range = !bus.x[CORDW-1] && (bus.x < CORDW'(FB_WIDTH)) &&
                      !y_r[CORDW-1]   && (y_r   < CORDW'(FB_HEIGHT));

    assign slot     = bus.x[SLOTW-1:0];
    assign pix_idx  = ADDRW'(y_r) * ADDRW'(WPL) + ADDRW'(bus.x[CORDW-1:SLOTW]);
    assign pix_mask = PPW'(1) << slot;
    assign pix_data = WORD'(colr_r) << (slot * BPP);
    assign pix_clr  = WORD'({BPP{1'b1}}) << (slot * BPP);

    assign pix_ok = bus.oe && bus.valid && in_range;
    // An index change with a non-empty accumulator forces the old word out.
    assign wchg   = pix_ok && (acc_mask != '0) && (pix_idx != acc_idx);

    // Accumulator contents after merging this cycle's pixel (no word change).
    assign merge_idx  = pix_ok ? pix_idx : acc_idx;
    assign merge_mask = pix_ok ? (acc_mask | pix_mask) : acc_mask;
    assign merge_data = pix_ok ? ((acc_data & ~pix_clr) | pix_data) : acc_data;

    always_comb begin
        state_next  = state;
        issue_final = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = ACCUM;
            end
            ACCUM: begin
                if (wchg) begin
                    state_next = WRITE;
                end else if (bus.flush) begin
                    if (merge_mask != '0) begin
                        state_next  = WRITE;
                        issue_final = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                if (bus.mem_ready) begin
                    if (final_r)         state_next = IDLE;
                    else if (flush_pend) state_next = WRITE;
                    else                 state_next = ACCUM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            y_r           <= '0;
            colr_r        <= '0;
            acc_idx       <= '0;
            acc_mask      <= '0;
            acc_data      <= '0;
            flush_pend    <= 1'b0;
            final_r       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_data  <= '0;
            bus.mem_mask  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        y_r        <= bus.y;
                        colr_r     <= bus.colr;
                        acc_mask   <= '0;
                        acc_data   <= '0;
                        flush_pend <= 1'b0;
                        final_r    <= 1'b0;
                        bus.busy   <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (wchg) begin
                        bus.mem_addr  <= acc_idx;
                        bus.mem_data  <= acc_data;
                        bus.mem_mask  <= acc_mask;
                        bus.mem_valid <= 1'b1;
                        acc_idx       <= pix_idx;
                        acc_mask      <= pix_mask;
                        acc_data      <= pix_data;
                        // The reloaded pixel still has to go out after this write.
                        flush_pend    <= bus.flush;
                        final_r       <= 1'b0;
                    end else begin
                        acc_idx  <= merge_idx;
                        acc_mask <= merge_mask;
                        acc_data <= merge_data;
                        if (issue_final) begin
                            bus.mem_addr  <= merge_idx;
                            bus.mem_data  <= merge_data;
                            bus.mem_mask  <= merge_mask;
                            bus.mem_valid <= 1'b1;
                            flush_pend    <= 1'b0;
                            final_r       <= 1'b1;
                        end else if (bus.flush) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        if (final_r) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            acc_mask <= '0;
                            final_r  <= 1'b0;
                        end else if (flush_pend) begin
                            // Back-to-back: present the leftover word next cycle.
                            bus.mem_addr  <= acc_idx;
                            bus.mem_data  <= acc_data;
                            bus.mem_mask  <= acc_mask;
                            bus.mem_valid <= 1'b1;
                            final_r       <= 1'b1;
                            flush_pend    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/span_pixel_writer.md
Name: span_pixel_writer

Overview:
- Consumer end of the span pixel stream produced by the fast line/fill generator.
- Accepts one x coordinate per handshake on a fixed row y with a fixed colour.
- Packs adjacent pixels into framebuffer words with a per-pixel write mask, and issues masked word writes to the framebuffer memory port.
- Sits between the fill generator and the framebuffer arbiter. Its oe output drives the generator's oe input.

Parameters:
- CORDW, 16, signed coordinate width.
- WORD, 32, memory data width (bits).
- BPP, 4, bits per pixel. WORD/BPP must be a power of two.
- FB_WIDTH, 640, framebuffer width (pixels). Must be a multiple of WORD/BPP.
- FB_HEIGHT, 480, framebuffer height (pixels).
- ADDRW, 16, word address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin span; latches y and colr
- y  in  CORDW  signed row for the span
- colr  in  BPP  pixel colour for the span
- x  in  CORDW  signed pixel x from the generator
- valid  in  1  x valid
- flush  in  1  end of span (connect to generator done)
- oe  out  1  ready for x (drives generator oe)
- busy  out  1  span in progress
- done  out  1  all writes for the span complete; one-cycle pulse
- mem_addr  out  ADDRW  word address
- mem_data  out  WORD  write data
- mem_mask  out  WORD/BPP  per-pixel write enable; bit i covers data bits [i*BPP +: BPP]
- mem_valid  out  1  write request
- mem_ready  in  1  memory accepts request

Behaviour:
- Definitions: PPW = WORD/BPP; WPL = FB_WIDTH/PPW.
  - Word index = y*WPL + (x / PPW), truncated to ADDRW.
  - Slot = x % PPW. Slot 0 is at the data LSBs.
- Reset: state IDLE. oe=0, busy=0, done=0, mem_valid=0, accumulator mask=0, flush_pend=0. mem_addr and mem_data are don't-care while mem_valid=0.
- States: IDLE, ACCUM, WRITE.
- IDLE:
  - done<=0.
  - On start: latch y and colr, clear the accumulator, busy<=1, go to ACCUM.
  - start outside IDLE is ignored.
- ACCUM:
  - oe=1 combinationally, in this state only.
  - On valid with a clipped pixel (x<0, x>=FB_WIDTH, y<0 or y>=FB_HEIGHT): the pixel is consumed and discarded.
  - On valid with a pixel in range:
    - If the accumulator mask is 0, or the word index equals the accumulated index: set mask bit [slot] and write colr into that slot.
    - Otherwise: copy the accumulator to the output registers and set mem_valid<=1. Reload the accumulator with the new pixel alone (new index, single mask bit). Go to WRITE.
  - On flush (same cycle as valid or not):
    - Any accepted pixel is merged first.
    - If a word-change write is also being issued this cycle, set flush_pend=1.
    - Otherwise, if the mask is non-zero: issue the accumulator as a write, set flush_pend=0, mark final, go to WRITE.
    - Otherwise (mask zero): go to IDLE, busy<=0, done<=1.
- WRITE:
  - oe=0. mem_addr, mem_data and mem_mask are held stable while mem_valid=1 and mem_ready=0.
  - On mem_ready: mem_valid<=0.
    - If final: go to IDLE, busy<=0, done<=1 on the next cycle. Clear the mask.
    - Else if flush_pend: issue the accumulator as the final write immediately (mem_valid stays high one cycle later), clear flush_pend.
    - Else: return to ACCUM.
- Throughput:
  - One pixel per cycle within a word.
  - A word change costs at least 1 cycle of oe=0 plus memory latency.
- Latency: the first write request is issued 1 cycle after the first pixel of the following word is accepted, or 1 cycle after flush.
- Ordering: x is normally monotonic. Non-monotonic x is legal; any index change forces a write, so no pixel is lost.
- Unwritten slots: mem_data bits for slots with mask=0 are 0.
- Empty span: flush with an empty mask and no prior pixels gives done one cycle after flush, with no write.
- Reset mid-span: all state returns to reset values. An outstanding mem_valid drops immediately and the pending write is abandoned.

Test Plan:
- Basic span: start y=2 colr=5, x=3..10, then flush -> two writes. addr=160, mask=0xF8, data=0x55555000; then addr=161, mask=0x07, data=0x00000555; done pulses once; busy falls with done.
- Backpressure: same span with mem_ready held low 5 cycles on the first write -> addr, data and mask stable, oe=0 throughout, no pixel lost, identical writes.
- Clipping: y=0 colr=0xF, x=-3..2, then flush -> a single write with addr=0, mask=0x07, data=0x00000FFF. Pixels -3..-1 are consumed with no write.
- Fully clipped or empty: y=480 with x=0..7 and flush, or flush with no pixels -> no mem_valid, done one cycle after flush.
- Flush together with a word change: x=6,7,8, with flush on the same cycle as x=8 -> write addr=0, mask=0xC0, then write addr=1, mask=0x01, then done.
- Reset mid-write: assert rst while mem_valid=1 -> next cycle mem_valid=0, busy=0, oe=0, done=0. A new start runs a clean span.
